stream_harness: RTL

- Reusable, parametrised simulation/bring-up harness that sits between a test top and the SoC's byte-stream console ports.
- Sequences the SoC reset and injects a preloaded stimulus stream into the SoC's input channel (valid/ready).
- Captures the SoC's output stream into a readable buffer.
- Ends a run on a terminator byte or a cycle timeout, replacing ad-hoc fixed delays with observable status.

---
 rtl/stream_harness_pkg.sv | 20 ++
 rtl/stream_fifo.sv | 54 +++++
 rtl/stream_harness.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stream_harness_pkg.sv
// rtl/stream_harness_pkg.sv - shared state encoding, constants and width helper for the stream harness
package stream_harness_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   localparam logic [7:0] DEFAULT_END_BYTE = 8'h04;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - synchronous FIFO with valid/ready on both sides, power-of-2 depth
module stream_fifo
   import stream_harness_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              push;
   logic              pop;
   logic              full;

   assign full     = (count == FULL_COUNT);
   assign rd_valid = (count != '0);
   assign rd_data  = mem[rd_ptr];
   assign pop      = rd_valid && rd_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
   assign wr_ready = !full || pop;
   assign push     = wr_valid && wr_ready;

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW + 1)'(1);
         else if (pop && !push) count <= count - (AW + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/stream_harness.sv
// rtl/stream_harness.sv - SoC reset sequencing, stimulus injection and output capture with terminator/timeout
module stream_harness
   import stream_harness_pkg::*;
#(
   parameter int                DATA_W       = 8,
   parameter int                STIM_DEPTH   = 16,
   parameter int                CAP_DEPTH    = 32,
   parameter int                RESET_CYCLES = 1,
   parameter int                STIM_DELAY   = 4,
   parameter int                TIMEOUT      = 1600,
   parameter logic [DATA_W-1:0] END_BYTE     = DATA_W'(DEFAULT_END_BYTE),
   parameter bit                CAP_WRAP     = 1'b0,
   localparam int               CAP_AW       = clog2(CAP_DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   output logic              soc_reset,
   input  logic              stim_wr_valid,
   output logic              stim_wr_ready,
   input  logic [DATA_W-1:0] stim_wr_data,
   output logic              dut_tx_valid,
   input  logic              dut_tx_ready,
   output logic [DATA_W-1:0] dut_tx_data,
   input  logic              dut_rx_valid,
   output logic              dut_rx_ready,
   input  logic [DATA_W-1:0] dut_rx_data,
   input  logic [CAP_AW-1:0] cap_rd_addr,
   output logic [DATA_W-1:0] cap_rd_data,
   output logic [CAP_AW:0]   cap_count,
   output logic              done,
   output logic              timed_out,
   output logic              running
);

   localparam int HOLD_W  = clog2(RESET_CYCLES) + 1;
   localparam int RUN_MAX = (TIMEOUT > STIM_DELAY) ? TIMEOUT : STIM_DELAY;
   localparam int RUN_W   = clog2(RUN_MAX) + 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST   = RUN_W'(TIMEOUT - 1);
   localparam logic [RUN_W-1:0]  STIM_START = RUN_W'(STIM_DELAY);
   localparam logic [CAP_AW:0]   CAP_FULL   = (CAP_AW + 1)'(CAP_DEPTH);

   state_t            state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [RUN_W-1:0]  run_cnt;
   logic              end_pend;
   logic              stim_en;
   logic              fifo_wr_ready;
   logic              fifo_valid;
   logic              rx_fire;
   logic              cap_full;
   logic [CAP_AW-1:0] cap_wr_ptr;
   logic [CAP_AW-1:0] cap_base;
   logic [DATA_W-1:0] cap_mem [CAP_DEPTH];

   assign soc_reset = (state == ST_HOLD);
   assign running   = (state == ST_RUN);
   assign done      = (state == ST_DONE);
   assign timed_out = (state == ST_TIMEOUT);

   // Preload is only accepted while the harness is out of reset and not yet terminated.
   assign stim_wr_ready = reset && (state == ST_HOLD || state == ST_RUN) && fifo_wr_ready;
   assign stim_en       = running && (run_cnt >= STIM_START);
   assign dut_tx_valid  = stim_en && fifo_valid;

   assign cap_full     = (cap_count == CAP_FULL);
   assign dut_rx_ready = running && !end_pend && (CAP_WRAP || !cap_full);
   assign rx_fire      = dut_rx_valid && dut_rx_ready;
   assign cap_rd_data  = cap_mem[cap_base + cap_rd_addr];

   stream_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (STIM_DEPTH)
   ) u_stim_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_valid (stim_wr_valid && stim_wr_ready),
      .wr_ready (fifo_wr_ready),
      .wr_data  (stim_wr_data),
      .rd_valid (fifo_valid),
      .rd_ready (stim_en && dut_tx_ready),
      .rd_data  (dut_tx_data)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= ST_HOLD;
         hold_cnt <= '0;
         run_cnt  <= '0;
         end_pend <= 1'b0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (hold_cnt == HOLD_LAST) state <= ST_RUN;
               else                       hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            ST_RUN: begin
               // Timeout wins over a terminator seen on the same edge.
               if (run_cnt == RUN_LAST) begin
                  state <= ST_TIMEOUT;
               end else begin
                  run_cnt <= run_cnt + RUN_W'(1);
                  if (end_pend)                                    state <= ST_DONE;
                  else if (rx_fire && dut_rx_data == END_BYTE)     end_pend <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cap_wr_ptr <= '0;
         cap_base   <= '0;
         cap_count  <= '0;
      end else if (rx_fire) begin
         cap_wr_ptr <= cap_wr_ptr + CAP_AW'(1);
         // Only reachable when full in wrap mode: drop the oldest entry.
         if (cap_full) cap_base  <= cap_base + CAP_AW'(1);
         else          cap_count <= cap_count + (CAP_AW + 1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (rx_fire) cap_mem[cap_wr_ptr] <= dut_rx_data;
   end

endmodule
